// File: rtl/azimuth_frame_loader_pkg.sv
// Shared definitions for the azimuth frame loader and the azimuth signal
// generator it feeds.
//
// Contents:
//   WORD_W_DEF     - default stream word width
//   loader_state_e - loader FSM states (FILL, FULL, RESYNC)
//   clogb2()       - bits needed to index 'value' entries (minimum 1)
//   words_for()    - number of stream words carrying one frame of 'size' bits
package azimuth_frame_loader_pkg;

  localparam int WORD_W_DEF = 32;

  typedef enum logic [1:0] {
    LD_FILL   = 2'd0,
    LD_FULL   = 2'd1,
    LD_RESYNC = 2'd2
  } loader_state_e;

  // Returns ceil(log2(value)), never less than 1 so that a one-entry
  // buffer still gets a legal index width.
  function automatic int clogb2(input int value);
    int bits;
    int rem;
    bits = 0;
    rem  = value - 1;
    while (rem > 0) begin
      bits = bits + 1;
      rem  = rem >> 1;
    end
    if (bits < 1) bits = 1;
    return bits;
  endfunction

  function automatic int words_for(input int size, input int word_w);
    return (size + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/azimuth_frame_loader_shadow_buffer.sv
// az_shadow_buffer: word-addressed shadow store for one azimuth frame.
//
// Ports:
//   clk     - system clock (storage has no reset; contents are don't-care
//             until a full frame has been written)
//   we      - write enable for the word at idx
//   idx     - word slot to write (0 .. WORDS-1)
//   word    - word data; bit 0 lands on frame bit idx*WORD_W
//   rd_data - whole frame, parallel read; padding bits at or above SIZE in
//             the last word never reach this output
module az_shadow_buffer
  import azimuth_frame_loader_pkg::*;
#(
  parameter int SIZE   = 3200,
  parameter int WORD_W = WORD_W_DEF,
  parameter int WORDS  = words_for(SIZE, WORD_W),
  parameter int IDX_W  = clogb2(WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] word,
  output logic [SIZE-1:0]   rd_data
);

  logic [WORD_W-1:0] mem_q [WORDS];
  logic [WORD_W-1:0] mem_d [WORDS];

  always_comb begin
    for (int k = 0; k < WORDS; k++) begin
      mem_d[k] = mem_q[k];
      if (we && (int'(idx) == k)) mem_d[k] = word;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < WORDS; k++) begin
      mem_q[k] <= mem_d[k];
    end
  end

  // Only frame bits below SIZE are routed out, which drops the padding in
  // the last word.
  always_comb begin
    rd_data = '0;
    for (int b = 0; b < SIZE; b++) begin
      rd_data[b] = mem_q[b / WORD_W][b % WORD_W];
    end
  end

endmodule

// File: rtl/azimuth_frame_loader.sv
// azimuth_frame_loader: assembles one azimuth bitmap frame from an AXI4-Stream
// into a shadow buffer and swaps it into the active DATA register on every
// antenna reference pulse (ARP), emitting TRIG aligned with the new DATA.
//
// Ports:
//   SYS_CLK, SYS_RESETN - clock and asynchronous active-low reset
//   S_AXIS_*            - frame words in; TLAST marks the last word
//   ARP                 - single-cycle rotation pulse
//   DATA, TRIG          - active frame and restart pulse to the generator
//   FRAME_READY         - shadow holds a complete frame
//   UNDERRUN            - pulse: ARP with no complete frame
//   LOAD_ERR            - pulse: TLAST framing violation
//   UNDERRUN_CNT        - saturating underrun count
//
// Build option: define AZ_LOADER_UNDERRUN_BLANK_EN to blank DATA on an
// underrun; otherwise DATA keeps repeating the previous frame.
module azimuth_frame_loader
  import azimuth_frame_loader_pkg::*;
#(
  parameter int SIZE   = 3200,
  parameter int WORD_W = WORD_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              SYS_CLK,
  input  logic              SYS_RESETN,
  input  logic [WORD_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic              S_AXIS_TLAST,
  input  logic              ARP,
  output logic [SIZE-1:0]   DATA,
  output logic              TRIG,
  output logic              FRAME_READY,
  output logic              UNDERRUN,
  output logic              LOAD_ERR,
  output logic [CNT_W-1:0]  UNDERRUN_CNT
);

  localparam int WORDS = words_for(SIZE, WORD_W);
  localparam int IDX_W = clogb2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  loader_state_e     state_q, state_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic [SIZE-1:0]   data_q, data_d;
  logic              trig_q, trig_d;
  logic              underrun_q, underrun_d;
  logic              load_err_q, load_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tready_q, tready_d;
  logic              frame_ready_q, frame_ready_d;

  logic              handshake;
  logic              shadow_we;
  logic [SIZE-1:0]   shadow_data;

  az_shadow_buffer #(
    .SIZE   (SIZE),
    .WORD_W (WORD_W),
    .WORDS  (WORDS),
    .IDX_W  (IDX_W)
  ) u_shadow (
    .clk     (SYS_CLK),
    .we      (shadow_we),
    .idx     (word_idx_q),
    .word    (S_AXIS_TDATA),
    .rd_data (shadow_data)
  );

  // Next-state logic. Stream handling runs first; ARP handling afterwards
  // may override the state, so a completing word and an ARP in the same
  // cycle count as an underrun while the frame still lands in FULL.
  always_comb begin
    handshake     = S_AXIS_TVALID & tready_q;
    state_d       = state_q;
    word_idx_d    = word_idx_q;
    data_d        = data_q;
    trig_d        = ARP;
    underrun_d    = 1'b0;
    load_err_d    = 1'b0;
    cnt_d         = cnt_q;
    shadow_we     = 1'b0;

    case (state_q)
      LD_FILL: begin
        if (handshake) begin
          shadow_we = 1'b1;
          if (S_AXIS_TLAST) begin
            if (word_idx_q == LAST_IDX) begin
              state_d = LD_FULL;
            end else begin
              load_err_d = 1'b1;
              word_idx_d = '0;
            end
          end else if (word_idx_q == LAST_IDX) begin
            load_err_d = 1'b1;
            word_idx_d = '0;
            state_d    = LD_RESYNC;
          end else begin
            word_idx_d = word_idx_q + IDX_W'(1);
          end
        end
      end
      LD_RESYNC: begin
        if (handshake && S_AXIS_TLAST) begin
          state_d    = LD_FILL;
          word_idx_d = '0;
        end
      end
      LD_FULL: begin
      end
      default: begin
        state_d    = LD_FILL;
        word_idx_d = '0;
      end
    endcase

    if (ARP) begin
      if (state_q == LD_FULL) begin
        data_d     = shadow_data;
        state_d    = LD_FILL;
        word_idx_d = '0;
      end else begin
        underrun_d = 1'b1;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
`ifdef AZ_LOADER_UNDERRUN_BLANK_EN
        data_d = '0;
`endif
      end
    end

    // Registered from the next state so both are low straight out of reset
    // and TREADY rises in the cycle after a swap.
    tready_d      = (state_d != LD_FULL);
    frame_ready_d = (state_d == LD_FULL);
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RESETN) begin
    if (!SYS_RESETN) begin
      state_q       <= LD_FILL;
      word_idx_q    <= '0;
      data_q        <= '0;
      trig_q        <= 1'b0;
      underrun_q    <= 1'b0;
      load_err_q    <= 1'b0;
      cnt_q         <= '0;
      tready_q      <= 1'b0;
      frame_ready_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_idx_q    <= word_idx_d;
      data_q        <= data_d;
      trig_q        <= trig_d;
      underrun_q    <= underrun_d;
      load_err_q    <= load_err_d;
      cnt_q         <= cnt_d;
      tready_q      <= tready_d;
      frame_ready_q <= frame_ready_d;
    end
  end

  assign S_AXIS_TREADY = tready_q;
  assign DATA          = data_q;
  assign TRIG          = trig_q;
  assign FRAME_READY   = frame_ready_q;
  assign UNDERRUN      = underrun_q;
  assign LOAD_ERR      = load_err_q;
  assign UNDERRUN_CNT  = cnt_q;

endmodule

// File: tb/tb_azimuth_frame_loader.sv
// Testbench for azimuth_frame_loader. Uses a frame size that leaves padding
// in the last word and a narrow underrun counter so saturation is reached
// quickly. Expected outputs come from a transaction-level frame model.
module tb_azimuth_frame_loader;

  localparam int SIZE_TB    = 3190;
  localparam int WORD_W_TB  = 32;
  localparam int CNT_W_TB   = 4;
  localparam int WORDS_TB   = (SIZE_TB + WORD_W_TB - 1) / WORD_W_TB;
  localparam int CNT_MAX_TB = (1 << CNT_W_TB) - 1;

  logic                 SYS_CLK;
  logic                 SYS_RESETN;
  logic [WORD_W_TB-1:0] S_AXIS_TDATA;
  logic                 S_AXIS_TVALID;
  logic                 S_AXIS_TREADY;
  logic                 S_AXIS_TLAST;
  logic                 ARP;
  logic [SIZE_TB-1:0]   DATA;
  logic                 TRIG;
  logic                 FRAME_READY;
  logic                 UNDERRUN;
  logic                 LOAD_ERR;
  logic [CNT_W_TB-1:0]  UNDERRUN_CNT;

  azimuth_frame_loader #(
    .SIZE   (SIZE_TB),
    .WORD_W (WORD_W_TB),
    .CNT_W  (CNT_W_TB)
  ) dut (
    .SYS_CLK       (SYS_CLK),
    .SYS_RESETN    (SYS_RESETN),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .ARP           (ARP),
    .DATA          (DATA),
    .TRIG          (TRIG),
    .FRAME_READY   (FRAME_READY),
    .UNDERRUN      (UNDERRUN),
    .LOAD_ERR      (LOAD_ERR),
    .UNDERRUN_CNT  (UNDERRUN_CNT)
  );

  // 100 MHz system clock
  initial SYS_CLK = 1'b0;
  always #5 SYS_CLK = ~SYS_CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: the words received so far for the frame in progress,
  // whether a complete frame is waiting, and whether the rest of an
  // over-long frame is being thrown away.
  logic [WORD_W_TB-1:0] shadowModel [WORDS_TB];
  int                   received;
  bit                   haveFrame;
  bit                   dropping;

  logic [SIZE_TB-1:0]   expData;
  bit                   expTrig;
  bit                   expUnderrun;
  bit                   expLoadErr;
  bit                   expReady;
  bit                   expFrameReady;
  int                   expCnt;

  // Compares one observed value with its expected value and counts it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [SIZE_TB-1:0] frameImage();
    logic [WORDS_TB*WORD_W_TB-1:0] img;
    for (int k = 0; k < WORDS_TB; k++) img[k*WORD_W_TB +: WORD_W_TB] = shadowModel[k];
    return img[SIZE_TB-1:0];
  endfunction

  task automatic modelReset();
    received      = 0;
    haveFrame     = 1'b0;
    dropping      = 1'b0;
    expData       = '0;
    expTrig       = 1'b0;
    expUnderrun   = 1'b0;
    expLoadErr    = 1'b0;
    expReady      = 1'b0;
    expFrameReady = 1'b0;
    expCnt        = 0;
  endtask

  // Advances the model by one clock with the inputs present before the edge
  task automatic modelStep(input bit v, input logic [WORD_W_TB-1:0] d,
                           input bit l, input bit a);
    bit accepted;
    bit completes;
    accepted    = v && expReady;
    completes   = 1'b0;
    expLoadErr  = 1'b0;
    expUnderrun = 1'b0;
    if (accepted) begin
      if (dropping) begin
        if (l) dropping = 1'b0;
      end else begin
        shadowModel[received] = d;
        if (l && received + 1 == WORDS_TB) begin
          completes = 1'b1;
          received  = 0;
        end else if (l) begin
          expLoadErr = 1'b1;
          received   = 0;
        end else if (received + 1 == WORDS_TB) begin
          expLoadErr = 1'b1;
          dropping   = 1'b1;
          received   = 0;
        end else begin
          received++;
        end
      end
    end
    expTrig = a;
    if (a) begin
      if (haveFrame) begin
        expData   = frameImage();
        haveFrame = 1'b0;
      end else begin
        expUnderrun = 1'b1;
        if (expCnt < CNT_MAX_TB) expCnt++;
`ifdef AZ_LOADER_UNDERRUN_BLANK_EN
        expData = '0;
`endif
      end
    end
    if (completes) haveFrame = 1'b1;
    expReady      = !haveFrame;
    expFrameReady = haveFrame;
  endtask

  task automatic checkAll();
    logic [WORDS_TB*WORD_W_TB-1:0] obsPad;
    logic [WORDS_TB*WORD_W_TB-1:0] expPad;
    checkOutput("TRIG", 32'(TRIG), 32'(expTrig));
    checkOutput("UNDERRUN", 32'(UNDERRUN), 32'(expUnderrun));
    checkOutput("LOAD_ERR", 32'(LOAD_ERR), 32'(expLoadErr));
    checkOutput("TREADY", 32'(S_AXIS_TREADY), 32'(expReady));
    checkOutput("FRAME_READY", 32'(FRAME_READY), 32'(expFrameReady));
    checkOutput("UNDERRUN_CNT", 32'(UNDERRUN_CNT), 32'(expCnt));
    obsPad = '0;
    expPad = '0;
    obsPad[SIZE_TB-1:0] = DATA;
    expPad[SIZE_TB-1:0] = expData;
    for (int k = 0; k < WORDS_TB; k++) begin
      if (obsPad[k*WORD_W_TB +: WORD_W_TB] !== expPad[k*WORD_W_TB +: WORD_W_TB])
        checkOutput($sformatf("DATA_w%0d", k), obsPad[k*WORD_W_TB +: WORD_W_TB],
                    expPad[k*WORD_W_TB +: WORD_W_TB]);
      else
        checks++;
    end
  endtask

  // Drives one cycle of inputs from a falling edge, steps the model and
  // checks every output at the next falling edge.
  task automatic applyStimulus(input bit v, input logic [WORD_W_TB-1:0] d,
                               input bit l, input bit a);
    S_AXIS_TVALID = v;
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = l;
    ARP           = a;
    modelStep(v, d, l, a);
    @(posedge SYS_CLK);
    @(negedge SYS_CLK);
    checkAll();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, WORD_W_TB'($urandom), 1'b0, 1'b0);
  endtask

  // Streams nWords words (TLAST on the last). Words are k or random,
  // with random valid gaps and random ARPs. arpAtLast forces an ARP in the
  // cycle of the final handshake. A word stuck behind a full shadow gets an
  // ARP after a while so the stream keeps moving.
  task automatic sendFrame(input int nWords, input bit randomData, input int gapPct,
                           input int arpPct, input bit arpAtLast);
    for (int w = 0; w < nWords; w++) begin
      logic [WORD_W_TB-1:0] word;
      bit last;
      bit accepted;
      int waited;
      word     = randomData ? WORD_W_TB'($urandom) : WORD_W_TB'(w);
      last     = (w == nWords - 1);
      accepted = 1'b0;
      waited   = 0;
      while (!accepted) begin
        bit v;
        bit a;
        v = ($urandom_range(99) >= gapPct);
        a = ($urandom_range(99) < arpPct);
        if (waited > 40) a = 1'b1;
        if (arpAtLast && last && v && expReady) a = 1'b1;
        accepted = v && expReady;
        applyStimulus(v, word, last, a);
        waited++;
        if (!accepted && waited > 200) begin
          checkOutput("sendBudget", 32'(waited), 32'd200);
          break;
        end
      end
    end
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    SYS_RESETN    = 1'b0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TDATA  = '0;
    S_AXIS_TLAST  = 1'b0;
    ARP           = 1'b0;
    modelReset();
    repeat (3) @(negedge SYS_CLK);
    checkAll();
    SYS_RESETN = 1'b1;
    idle(2);

    $display("[TB] counting frame then swap");
    sendFrame(WORDS_TB, 1'b0, 0, 0, 1'b0);
    idle(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("swapWord0", DATA[31:0], 32'd0);
    checkOutput("swapWord1", DATA[63:32], 32'd1);
    checkOutput("swapWord50", DATA[50*32 +: 32], 32'd50);

    $display("[TB] underrun with no frame");
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("firstUnderrunCnt", 32'(UNDERRUN_CNT), 32'd1);
    idle(2);

    $display("[TB] short frame then full frame");
    sendFrame(50, 1'b1, 20, 0, 1'b0);
    sendFrame(WORDS_TB, 1'b1, 20, 0, 1'b0);
    idle(1);
    checkOutput("readyAfterShort", 32'(FRAME_READY), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] long frame then full frame");
    sendFrame(WORDS_TB + 3, 1'b1, 10, 0, 1'b0);
    sendFrame(WORDS_TB, 1'b1, 10, 0, 1'b0);
    idle(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] ARP on completing word");
    sendFrame(WORDS_TB, 1'b1, 0, 0, 1'b1);
    idle(1);
    applyStimulus(1'b1, WORD_W_TB'($urandom), 1'b0, 1'b1);
    idle(2);

    $display("[TB] underrun counter saturation");
    for (int i = 0; i < CNT_MAX_TB + 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("cntSaturated", 32'(UNDERRUN_CNT), CNT_MAX_TB);
    idle(2);

    $display("[TB] randomized frames");
    for (int f = 0; f < 16; f++) begin
      int r;
      int len;
      r = $urandom_range(99);
      if (r < 70) len = WORDS_TB;
      else if (r < 85) len = $urandom_range(1, WORDS_TB - 1);
      else len = $urandom_range(WORDS_TB + 1, WORDS_TB + 5);
      sendFrame(len, 1'b1, 30, 3, 1'b0);
      idle($urandom_range(0, 3));
    end

    $display("[TB] reset during fill");
    sendFrame(40, 1'b1, 0, 0, 1'b0);
    #2;
    SYS_RESETN = 1'b0;
    #1;
    modelReset();
    checkAll();
    repeat (2) @(negedge SYS_CLK);
    SYS_RESETN = 1'b1;
    sendFrame(WORDS_TB, 1'b1, 15, 0, 1'b0);
    idle(1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/azimuth_frame_loader.md
Name: azimuth_frame_loader

Overview:
- Upstream feeder for the azimuth signal generator. Receives one azimuth bitmap frame (SIZE bits) as 32-bit words over an AXI4-Stream slave and assembles it in a shadow buffer.
- On each antenna reference pulse (ARP), swaps the shadow into the active DATA register. Emits a one-cycle TRIG, aligned with the new DATA, to restart the generator's clock index.
- Double-buffered, so the DMA can refill during the current rotation.

Parameters:
- SIZE, 3200, bits per frame; must match the downstream generator.
- WORD_W, 32, stream word width.
- CNT_W, 16, width of the saturating underrun counter.

Ports:
- SYS_CLK  in  1  system clock, 100 MHz.
- SYS_RESETN  in  1  reset, asynchronous assert, active-low.
- S_AXIS_TDATA  in  WORD_W  frame word; bit 0 of word k is frame bit k*WORD_W.
- S_AXIS_TVALID  in  1  word valid.
- S_AXIS_TREADY  out  1  loader can accept a word.
- S_AXIS_TLAST  in  1  marks the final word of a frame.
- ARP  in  1  single-cycle rotation pulse, synchronous to SYS_CLK.
- DATA  out  SIZE  active frame, to the generator's DATA input.
- TRIG  out  1  one-cycle pulse, to the generator's TRIG input.
- FRAME_READY  out  1  shadow holds a complete frame.
- UNDERRUN  out  1  one-cycle pulse: ARP arrived with no complete frame.
- LOAD_ERR  out  1  one-cycle pulse: TLAST framing violation.
- UNDERRUN_CNT  out  CNT_W  saturating count of underruns.

Behaviour:
- Derived constants: WORDS = ceil(SIZE/WORD_W) (100 at defaults); IDX_W = clogb2(WORDS).
- Reset (asynchronous, SYS_RESETN=0):
  - DATA=0, TRIG=0, UNDERRUN=0, LOAD_ERR=0, UNDERRUN_CNT=0, FRAME_READY=0, S_AXIS_TREADY=0.
  - State=FILL, word_idx=0, shadow contents don't-care.
- States:
  - FILL: TREADY=1. On each handshake (TVALID&TREADY), write the word to shadow slot word_idx.
    - Word with TLAST=0 and word_idx<WORDS-1: word_idx++.
    - Word with TLAST=1 and word_idx==WORDS-1: go to FULL.
    - Word with TLAST=1 and word_idx<WORDS-1 (short frame): LOAD_ERR pulse; discard the partial frame; word_idx=0; stay in FILL.
    - Word with TLAST=0 and word_idx==WORDS-1 (long frame): LOAD_ERR pulse; go to RESYNC.
  - RESYNC: TREADY=1; drop words until a handshake with TLAST=1, then go to FILL with word_idx=0. No further LOAD_ERR pulses while in RESYNC.
  - FULL: TREADY=0; FRAME_READY=1.
- Padding bits at or above SIZE in the last word are ignored.
- ARP handling (evaluated on the registered state at the ARP cycle n):
  - State FULL: DATA<=shadow at n+1; go to FILL, word_idx=0.
  - Any other state: DATA holds its value; UNDERRUN pulses at n+1; UNDERRUN_CNT increments, saturating at 2^CNT_W-1. A partial fill continues undisturbed.
  - TRIG pulses at n+1 on every ARP, whether or not a swap occurred.
- Simultaneous events:
  - ARP in the same cycle as the completing word: counts as an underrun. The frame reaches FULL and swaps on the next ARP.
  - ARP while in FULL with TVALID high: the swap occurs and TREADY rises at n+1.
- Back-to-back ARPs in consecutive cycles are each handled independently.
- Latency: ARP to DATA/TRIG is 1 cycle. Last word handshake to FRAME_READY is 1 cycle.
- Reset mid-fill discards the shadow contents; the DMA must restart the frame.

Optional Feature:
- Macro: AZ_LOADER_UNDERRUN_BLANK_EN.
- Defined: on an underrun, DATA<=0 at n+1, so the generator outputs silence for that rotation.
- Undefined: DATA repeats the previous frame.
- UNDERRUN and UNDERRUN_CNT behave identically in both builds.

Decomposition:
- Shared package:
  - WORD_W default.
  - clogb2 function.
  - Loader state enum (FILL, FULL, RESYNC).
  - WORDS derivation, shared with the generator.
- Sub-module: az_shadow_buffer.
  - Word-addressed write port (we, idx, word).
  - Full-width parallel read.
  - Masks bits at or above SIZE.

Test Plan:
- Reset, then stream 100 words with word k=k, TLAST on word 99, then ARP → TRIG=1 at n+1; DATA[31:0]=0, DATA[63:32]=1; FRAME_READY falls at n+1; TREADY rises at n+1.
- ARP with no frame loaded → UNDERRUN pulse, UNDERRUN_CNT=1, DATA unchanged (all zeros from reset), TRIG still pulses. With the macro defined and DATA previously nonzero, DATA=0.
- TLAST on word 49 → LOAD_ERR pulse, word_idx=0. A following complete 100-word frame gives FRAME_READY=1.
- 103 words with TLAST on the last → LOAD_ERR pulse at word 99; words 100–102 dropped; the next 100-word frame loads correctly.
- ARP in the same cycle as word 99's handshake → UNDERRUN pulse; the next ARP swaps the frame.
- Force UNDERRUN_CNT to 0xFFFE, issue 3 underrun ARPs → count reads 0xFFFF and holds.
